// File: rtl/dct_frame_ctrl.sv
// Frame sequencer for the 2D-DCT datapath: walks a 512x512 image in 8x8 block order,
// streams row-words into the DCT core and writes its results back to the same addresses.
module dct_frame_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int ROW_WORDS  = 64,
  parameter int BLK_ROWS   = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              in_en,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [63:0]       in_rdata,
  output logic              dct_in_valid,
  output logic [63:0]       dct_in_data,
  input  logic              dct_in_ready,
  input  logic              dct_out_valid,
  input  logic [63:0]       dct_out_data,
  output logic              dct_out_ready,
  output logic              out_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [63:0]       out_wdata
);

  localparam int BX_W = $clog2(ROW_WORDS);
  localparam int BY_W = $clog2(BLK_ROWS);
  localparam logic [BX_W-1:0] BX_LAST = BX_W'(ROW_WORDS - 1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(BLK_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [2:0]      rd_r, wr_r;
  logic [BX_W-1:0] rd_bx, wr_bx;
  logic [BY_W-1:0] rd_by, wr_by;

  logic            inflight;
  logic [1:0]      count;
  logic            wptr, rptr;
  logic [63:0]     fifo_mem [FIFO_DEPTH];

  logic            pop;
  logic [2:0]      occ_after;
  logic            rd_last, wr_last;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [BY_W-1:0] by,
                                                input logic [2:0]      r,
                                                input logic [BX_W-1:0] bx);
    return ADDR_W'((32'(by) * 32'd8 + 32'(r)) * 32'(ROW_WORDS) + 32'(bx));
  endfunction

  assign dct_in_valid  = (count != 2'd0);
  assign dct_in_data   = fifo_mem[rptr];
  assign pop           = dct_in_valid & dct_in_ready;

  // Occupancy after this cycle's pop plus the read already in flight; a new read must fit.
  assign occ_after     = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign in_en         = (state == RUN) && (occ_after < 3'(FIFO_DEPTH));
  assign in_addr       = addr_of(rd_by, rd_r, rd_bx);

  assign dct_out_ready = busy;
  assign out_en        = dct_out_valid & busy;
  assign out_we        = out_en;
  assign out_addr      = addr_of(wr_by, wr_r, wr_bx);
  assign out_wdata     = out_en ? dct_out_data : 64'd0;

  assign rd_last = (rd_r == 3'd7) && (rd_bx == BX_LAST) && (rd_by == BY_LAST);
  assign wr_last = (wr_r == 3'd7) && (wr_bx == BX_LAST) && (wr_by == BY_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 64'd0;
    end else begin
      inflight <= in_en;
      if (inflight) begin
        fifo_mem[wptr] <= in_rdata;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_r  <= 3'd0;
      rd_bx <= '0;
      rd_by <= '0;
      wr_r  <= 3'd0;
      wr_bx <= '0;
      wr_by <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            rd_r  <= 3'd0;
            rd_bx <= '0;
            rd_by <= '0;
            wr_r  <= 3'd0;
            wr_bx <= '0;
            wr_by <= '0;
          end
        end
        RUN: begin
          // The last read freezes the read counters instead of wrapping them.
          if (in_en) begin
            if (rd_last) begin
              state <= DRAIN;
            end else if (rd_r == 3'd7) begin
              rd_r <= 3'd0;
              if (rd_bx == BX_LAST) begin
                rd_bx <= '0;
                rd_by <= rd_by + BY_W'(1);
              end else begin
                rd_bx <= rd_bx + BX_W'(1);
              end
            end else begin
              rd_r <= rd_r + 3'd1;
            end
          end
        end
        DRAIN: ;
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (out_en) begin
        if (wr_last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (wr_r == 3'd7) begin
          wr_r <= 3'd0;
          if (wr_bx == BX_LAST) begin
            wr_bx <= '0;
            wr_by <= wr_by + BY_W'(1);
          end else begin
            wr_bx <= wr_bx + BX_W'(1);
          end
        end else begin
          wr_r <= wr_r + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_frame_ctrl.sv
// Bench for dct_frame_ctrl: SRAM models plus a 3-cycle loopback DCT, with a block-order
// address model checked every cycle and a few literal expectations at the end.
module tb_dct_frame_ctrl;

  localparam int FRAME = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        in_en;
  logic [14:0] in_addr;
  logic [63:0] in_rdata;
  logic        dct_in_valid;
  logic [63:0] dct_in_data;
  logic        dct_in_ready;
  logic        dct_out_valid;
  logic [63:0] dct_out_data;
  logic        dct_out_ready;
  logic        out_en;
  logic        out_we;
  logic [14:0] out_addr;
  logic [63:0] out_wdata;

  logic        stray_valid;
  logic [63:0] mem_in   [FRAME];
  logic [63:0] mem_out  [FRAME];
  logic [14:0] exp_addr [FRAME];
  logic [14:0] rd_log   [FRAME];
  int          wcount   [FRAME];
  logic        pipe_v   [3];
  logic [63:0] pipe_d   [3];
  logic        bp_pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [14:0] first_addrs [9] = '{15'd0, 15'd64, 15'd128, 15'd192, 15'd256,
                                   15'd320, 15'd384, 15'd448, 15'd1};

  int   checks = 0;
  int   errors = 0;
  int   rd_idx = 0, fed_idx = 0, wr_idx = 0;
  int   cyc = 0, first_rd = 0, last_rd = 0, done_cnt = 0;
  logic exp_busy = 1'b0, exp_done = 1'b0, nxt_busy, nxt_done;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;

  always #5 clk = ~clk;

  dct_frame_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .in_en        (in_en),
    .in_addr      (in_addr),
    .in_rdata     (in_rdata),
    .dct_in_valid (dct_in_valid),
    .dct_in_data  (dct_in_data),
    .dct_in_ready (dct_in_ready),
    .dct_out_valid(dct_out_valid),
    .dct_out_data (dct_out_data),
    .dct_out_ready(dct_out_ready),
    .out_en       (out_en),
    .out_we       (out_we),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata)
  );

  function automatic logic [63:0] pat(input int a);
    return {32'(a) * 32'h9E37_79B1, 32'h5A5A_0000 ^ 32'(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (errors <= 50)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rdy);
    @(posedge clk);
    #1;
    start        = s;
    dct_in_ready = rdy;
  endtask

  always @(posedge clk) if (in_en) in_rdata <= mem_in[in_addr];
  always @(posedge clk) if (out_en && out_we) mem_out[out_addr] <= out_wdata;

  // Loopback DCT: every accepted input word reappears unchanged three cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= 64'd0;
      end
    end else begin
      pipe_v[0] <= dct_in_valid && dct_in_ready;
      pipe_d[0] <= dct_in_data;
      pipe_v[1] <= pipe_v[0];
      pipe_d[1] <= pipe_d[0];
      pipe_v[2] <= pipe_v[1];
      pipe_d[2] <= pipe_d[1];
    end
  end
  assign dct_out_valid = pipe_v[2] | stray_valid;
  assign dct_out_data  = pipe_d[2];

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      checkOutput("reset_outputs",
                  {58'd0, busy, done, in_en, out_en, dct_in_valid, dct_out_ready}, 64'd0);
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      rd_idx     = 0;
      fed_idx    = 0;
      wr_idx     = 0;
      prev_stall = 1'b0;
    end else begin
      checkOutput("busy", busy, exp_busy);
      checkOutput("done", done, exp_done);
      checkOutput("out_ready", dct_out_ready, exp_busy);
      if (done) done_cnt++;

      if (!exp_busy || rd_idx >= FRAME) begin
        checkOutput("in_en_quiet", in_en, 1'b0);
      end else if (in_en) begin
        checkOutput("in_addr", in_addr, exp_addr[rd_idx]);
        rd_log[rd_idx] = in_addr;
        if (rd_idx == 0) first_rd = cyc;
        if (rd_idx == FRAME - 1) last_rd = cyc;
        rd_idx++;
      end

      if (!exp_busy || fed_idx >= FRAME) begin
        checkOutput("in_valid_quiet", dct_in_valid, 1'b0);
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", dct_in_valid, 1'b1);
          checkOutput("hold_data", dct_in_data, prev_data);
        end
        if (dct_in_valid && dct_in_ready) begin
          checkOutput("in_data", dct_in_data, pat(int'(exp_addr[fed_idx])));
          fed_idx++;
        end
      end
      prev_stall = dct_in_valid && !dct_in_ready;
      prev_data  = dct_in_data;
      checkOutput("occupancy_le2", (rd_idx - fed_idx <= 2), 1'b1);

      nxt_busy = exp_busy;
      nxt_done = 1'b0;
      if (!exp_busy || wr_idx >= FRAME) begin
        checkOutput("out_en_quiet", out_en, 1'b0);
      end else begin
        checkOutput("out_en", out_en, dct_out_valid);
        if (out_en) begin
          checkOutput("out_we", out_we, 1'b1);
          checkOutput("out_addr", out_addr, exp_addr[wr_idx]);
          checkOutput("out_wdata", out_wdata, pat(int'(exp_addr[wr_idx])));
          wcount[out_addr]++;
          wr_idx++;
          if (wr_idx == FRAME) begin
            nxt_busy = 1'b0;
            nxt_done = 1'b1;
          end
        end
      end
      if (!exp_busy && !exp_done && start) begin
        nxt_busy   = 1'b1;
        rd_idx     = 0;
        fed_idx    = 0;
        wr_idx     = 0;
        prev_stall = 1'b0;
        for (int a = 0; a < FRAME; a++) wcount[a] = 0;
      end
      exp_busy = nxt_busy;
      exp_done = nxt_done;
    end
  end

  initial begin
    int n;
    int miss;
    for (int a = 0; a < FRAME; a++) mem_in[a] = pat(a);
    n = 0;
    for (int by = 0; by < 64; by++)
      for (int bx = 0; bx < 64; bx++)
        for (int r = 0; r < 8; r++) begin
          exp_addr[n] = 15'(((by * 8 + r) * 64) + bx);
          n++;
        end

    reset        = 1'b0;
    start        = 1'b0;
    dct_in_ready = 1'b0;
    stray_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;

    repeat (20) applyStimulus(1'b0, 1'b1);
    stray_valid = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b1);
    stray_valid = 1'b0;

    // Backpressured frame, aborted by reset once about 1000 reads have gone out.
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (rd_idx < 1000 && n < 20000) begin
      applyStimulus(1'b0, bp_pat[n % 4]);
      n++;
    end
    checkOutput("bp_reached_read_1000", (rd_idx >= 1000), 1'b1);
    checkOutput("bp_writes_flowed", (wr_idx > 900), 1'b1);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    dct_in_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b1);

    // Full frame with ready held high, plus one start pulse while busy.
    applyStimulus(1'b1, 1'b1);
    repeat (200) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (done_cnt == 0 && n < 40000) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    checkOutput("frame_done_in_time", (done_cnt != 0), 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);

    for (int i = 0; i < 9; i++) checkOutput("first_addrs", rd_log[i], first_addrs[i]);
    checkOutput("addr_before_wrap", rd_log[511], 15'd511);
    checkOutput("addr_after_wrap", rd_log[512], 15'd512);
    checkOutput("final_read_addr", rd_log[FRAME-1], 15'd32767);
    checkOutput("read_burst_span", last_rd - first_rd, 32767);
    checkOutput("done_pulses", done_cnt, 1);

    n    = 0;
    miss = 0;
    for (int a = 0; a < FRAME; a++) begin
      if (mem_out[a] !== mem_in[a]) n++;
      if (wcount[a] != 1) miss++;
    end
    checkOutput("out_mem_equals_in_mem", n, 0);
    checkOutput("each_addr_written_once", miss, 0);
    checkOutput("out_mem_last_word", mem_out[FRAME-1], pat(32767));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
